// File: rtl/orbtrace_pkg.sv
// orbtrace_pkg: constants and types shared by the trace-to-UART path.
//   FRAME_BYTES_DEFAULT  default TPIU frame size in bytes
//   SYSCLK_HZ            system clock frequency (48 MHz PLL output)
//   TPIU_FRAME_W         width of one TPIU frame in bits
//   stage_t              output-stage state of pack_fifo_sender
package orbtrace_pkg;

  localparam int FRAME_BYTES_DEFAULT = 16;
  localparam int SYSCLK_HZ           = 48_000_000;
  localparam int TPIU_FRAME_W        = 128;

  typedef enum logic {
    ST_EMPTY,
    ST_SENDING
  } stage_t;

endpackage

// File: rtl/pack_fifo_sender_if.sv
// pack_fifo_sender_if: frame capture handshake plus serial byte stream.
//   pkt_avail/pkt_in/pkt_ack     frame offered by the trace front end, acked once
//   data_out/data_valid/data_ready  byte stream towards the UART
// Modport master is the sender side (captures frames, drives bytes);
// slave is the producer/consumer side.
interface pack_fifo_sender_if import orbtrace_pkg::*; #(
  parameter int FRAME_BYTES = TPIU_FRAME_W / 8
);

  logic                     pkt_avail;
  logic [8*FRAME_BYTES-1:0] pkt_in;
  logic                     pkt_ack;
  logic [7:0]               data_out;
  logic                     data_valid;
  logic                     data_ready;

  modport master (
    input  pkt_avail, pkt_in, data_ready,
    output pkt_ack, data_out, data_valid
  );

  modport slave (
    output pkt_avail, pkt_in, data_ready,
    input  pkt_ack, data_out, data_valid
  );

endinterface

// File: rtl/frame_fifo.sv
// frame_fifo: DEPTH x WIDTH synchronous FIFO with a registered head output.
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write wdata at the tail (caller guarantees space or same-edge pop)
//   pop             drop the head entry
//   head            registered copy of the current head entry
//   full, empty     occupancy flags
//   count           entries held (0..DEPTH)
module frame_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   ONE      = 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rd_next = pop ? rd_ptr + ONE : rd_ptr;
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      rd_ptr <= rd_next;
      // Head tracks the entry that will be at the front after this edge;
      // a push into an (about to be) empty FIFO bypasses the memory.
      head <= (push && rd_next == wr_ptr) ? wdata : mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/pack_fifo_sender.sv
// pack_fifo_sender: buffers whole TPIU frames and serialises them LSB byte first.
//   clk, rst     system clock, asynchronous active-high reset
//   sync         trace sync indicator; frames offered while low are dropped when SYNC_GATE=1
//   bus          frame handshake (pkt_*) and byte stream (data_*), master side
//   level        frames waiting in the FIFO (output stage not included)
//   ovf_count    frames lost to a full FIFO, saturating
//   ovf_led      held high for OVF_STRETCH cycles after the last overflow
module pack_fifo_sender import orbtrace_pkg::*; #(
  parameter int          FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int          DEPTH       = 4,
  parameter bit          SYNC_GATE   = 1'b1,
  parameter int unsigned OVF_STRETCH = SYSCLK_HZ / 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sync,
  pack_fifo_sender_if.master     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            ovf_count,
  output logic                   ovf_led
);

  localparam int              FW       = 8 * FRAME_BYTES;
  localparam int              IW       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int              SW       = $clog2(OVF_STRETCH + 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(FRAME_BYTES - 1);

  stage_t          state_q;
  stage_t          state_d;
  logic [FW-1:0]   sreg;
  logic [IW-1:0]   idx;
  logic            ack_q;
  logic [SW-1:0]   stretch;

  logic            capture;
  logic            keep;
  logic            accept;
  logic            pop;
  logic            push;
  logic            ovf;
  logic            fifo_full;
  logic            fifo_empty;
  logic [FW-1:0]   head;

  // The ack-low qualifier stops a second capture while the producer is
  // still reacting to the previous ack.
  assign capture = bus.pkt_avail && !ack_q;
  assign keep    = !(SYNC_GATE && !sync);
  assign accept  = (state_q == ST_SENDING) && bus.data_ready;
  assign push    = capture && keep && (!fifo_full || pop);
  assign ovf     = capture && keep && fifo_full && !pop;

  frame_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.pkt_in),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Reload on the last byte's handshake keeps frames back to back.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SENDING;
        end
      end
      ST_SENDING: begin
        if (bus.data_ready && idx == LAST_IDX) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Shift register presents byte[idx] at its bottom byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      idx  <= '0;
    end else if (pop) begin
      sreg <= head;
      idx  <= '0;
    end else if (accept) begin
      sreg <= sreg >> 8;
      idx  <= idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      ovf_count <= '0;
      stretch   <= '0;
    end else begin
      ack_q <= capture;
      if (ovf && ovf_count != '1) ovf_count <= ovf_count + 16'd1;
      if (ovf)                  stretch <= SW'(OVF_STRETCH);
      else if (stretch != '0)   stretch <= stretch - SW'(1);
    end
  end

  assign bus.pkt_ack    = ack_q;
  assign bus.data_out   = sreg[7:0];
  assign bus.data_valid = (state_q == ST_SENDING);
  assign ovf_led        = (stretch != '0);

endmodule

// File: tb/tb_pack_fifo_sender.sv
module tb_pack_fifo_sender;

  localparam int DEPTH   = 4;
  localparam int STRETCH = 16;
  localparam logic [127:0] FRAME0 = 128'h0F0E0D0C0B0A09080706050403020100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sync = 1'b1;
  logic         avail = 1'b0;
  logic         ready = 1'b0;
  logic [127:0] pin = '0;

  logic [2:0]   level0, level1;
  logic [15:0]  ovf0, ovf1;
  logic         led0, led1;

  pack_fifo_sender_if #(.FRAME_BYTES(16)) bus0 ();
  pack_fifo_sender_if #(.FRAME_BYTES(16)) bus1 ();

  assign bus0.pkt_avail  = avail;
  assign bus0.pkt_in     = pin;
  assign bus0.data_ready = ready;
  assign bus1.pkt_avail  = avail;
  assign bus1.pkt_in     = pin;
  assign bus1.data_ready = ready;

  pack_fifo_sender #(
    .FRAME_BYTES (16), .DEPTH (DEPTH), .SYNC_GATE (1'b1), .OVF_STRETCH (STRETCH)
  ) u0 (
    .clk (clk), .rst (rst), .sync (sync), .bus (bus0),
    .level (level0), .ovf_count (ovf0), .ovf_led (led0)
  );

  pack_fifo_sender #(
    .FRAME_BYTES (16), .DEPTH (DEPTH), .SYNC_GATE (1'b0), .OVF_STRETCH (STRETCH)
  ) u1 (
    .clk (clk), .rst (rst), .sync (sync), .bus (bus1),
    .level (level1), .ovf_count (ovf1), .ovf_led (led1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the gated instance: frames waiting, bytes still to send.
  bit           m_ack;
  logic [127:0] m_fifo[$];
  logic [7:0]   m_stage[$];
  int           m_ovf;
  int           m_stretch;

  logic [7:0]   got[$];
  logic [7:0]   got1[$];
  logic [7:0]   expq[$];

  typedef struct {
    bit         avail;
    bit         ready;
    bit         ack;
    bit         valid;
    logic [7:0] data;
    int         level;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd_frame();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void add_frame(input logic [127:0] f);
    for (int b = 0; b < 16; b++) expq.push_back(f[8*b +: 8]);
  endfunction

  task automatic chk_bytes(input string name, input logic [7:0] a[$], input logic [7:0] e[$]);
    int bad;
    bad = 0;
    chk({name, "_len"}, a.size(), e.size());
    for (int i = 0; i < a.size() && i < e.size(); i++)
      if (a[i] !== e[i]) bad++;
    chk({name, "_bytes_wrong"}, bad, 0);
  endtask

  function automatic void model_edge();
    bit cap, acc, pop;
    int n;
    logic [127:0] f;
    cap = avail && !m_ack;
    acc = (m_stage.size() != 0) && ready;
    n   = m_fifo.size();
    pop = (n != 0) && (m_stage.size() == 0 || (acc && m_stage.size() == 1));
    if (acc) void'(m_stage.pop_front());
    if (pop) begin
      f = m_fifo.pop_front();
      for (int b = 0; b < 16; b++) m_stage.push_back(f[8*b +: 8]);
    end
    if (m_stretch > 0) m_stretch--;
    if (cap && sync) begin
      if (n == DEPTH && !pop) begin
        if (m_ovf < 65535) m_ovf++;
        m_stretch = STRETCH;
      end else begin
        m_fifo.push_back(pin);
      end
    end
    m_ack = cap;
  endfunction

  function automatic void model_clear();
    m_ack = 0; m_fifo.delete(); m_stage.delete(); m_ovf = 0; m_stretch = 0;
  endfunction

  task automatic check_model();
    chk("pkt_ack", bus0.pkt_ack, m_ack);
    chk("data_valid", bus0.data_valid, m_stage.size() != 0);
    if (m_stage.size() != 0) chk("data_out", bus0.data_out, m_stage[0]);
    chk("level", level0, m_fifo.size());
    chk("ovf_count", ovf0, m_ovf);
    chk("ovf_led", led0, m_stretch != 0);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    if (bus0.data_valid && ready) got.push_back(bus0.data_out);
    if (bus1.data_valid && ready) got1.push_back(bus1.data_out);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic offer(input logic [127:0] f);
    bit seen;
    seen = 0;
    if (bus0.pkt_ack) tick();
    pin = f;
    avail = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (bus0.pkt_ack) seen = 1;
    end
    avail = 1'b0;
    chk("pkt_ack_seen", seen, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    avail = 1'b0;
    #1;
    chk("rst_pkt_ack", bus0.pkt_ack, 0);
    chk("rst_data_out", bus0.data_out, 0);
    chk("rst_data_valid", bus0.data_valid, 0);
    chk("rst_level", level0, 0);
    chk("rst_ovf_count", ovf0, 0);
    chk("rst_ovf_led", led0, 0);
    chk("rst_valid_ng", bus1.data_valid, 0);
    chk("rst_level_ng", level1, 0);
    chk("rst_ovf_ng", ovf1 + 16'(led1), 0);
    model_clear();
    got.delete(); got1.delete(); expq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, maxlev, anyv;
    logic [127:0] fa, fb, fc;
    logic [7:0] pd;
    bit pv, pr;

    // Single frame: capture, two-edge latency, 16 consecutive bytes.
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0};
    for (int i = 1; i < 16; i++) vt[i+1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'(i), 0};
    vt[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0};

    @(negedge clk);
    apply_reset();

    pin = FRAME0;
    for (int i = 0; i < 18; i++) begin
      avail = vt[i].avail;
      ready = vt[i].ready;
      tick();
      chk($sformatf("tbl%0d_ack", i), bus0.pkt_ack, vt[i].ack);
      chk($sformatf("tbl%0d_valid", i), bus0.data_valid, vt[i].valid);
      if (vt[i].valid) chk($sformatf("tbl%0d_data", i), bus0.data_out, vt[i].data);
      chk($sformatf("tbl%0d_level", i), level0, vt[i].level);
    end

    // Six frames against a stalled consumer: one in the stage, four queued, one lost.
    apply_reset();
    ready = 1'b0;
    for (int k = 0; k < 6; k++) offer(rnd_frame());
    chk("bb_level", level0, 4);
    chk("bb_ovf_count", ovf0, 1);
    chk("bb_valid", bus0.data_valid, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (led0) cnt++;
      tick();
    end
    chk("bb_led_cycles", cnt, STRETCH);
    ready = 1'b1;
    for (int i = 0; i < 90; i++) tick();
    chk("bb_drained_bytes", got.size(), 80);

    // Two queued frames stream with no gap.
    apply_reset();
    ready = 1'b0;
    fa = rnd_frame(); fb = rnd_frame();
    offer(fa); offer(fb);
    add_frame(fa); add_frame(fb);
    ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus0.data_valid) cnt++;
      tick();
    end
    chk("gap_valid_cycles", cnt, 32);
    chk("gap_idle_after", bus0.data_valid, 0);
    chk_bytes("gap", got, expq);

    // Alternating ready: byte holds while stalled, none lost or duplicated.
    got.delete(); expq.delete();
    ready = 1'b0;
    fc = rnd_frame();
    offer(fc);
    add_frame(fc);
    for (int i = 0; i < 40; i++) begin
      ready = i[0];
      pv = bus0.data_valid; pr = ready; pd = bus0.data_out;
      tick();
      if (pv && !pr) chk("stall_hold", bus0.data_out, pd);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_bytes("stall", got, expq);

    // Sync gate: gated instance acks and drops, ungated one sends the frame.
    apply_reset();
    sync = 1'b0;
    ready = 1'b1;
    fa = rnd_frame();
    offer(fa);
    add_frame(fa);
    maxlev = 0; anyv = 0;
    for (int i = 0; i < 25; i++) begin
      if (int'(level0) > maxlev) maxlev = int'(level0);
      if (bus0.data_valid) anyv = 1;
      tick();
    end
    chk("gate_level", maxlev, 0);
    chk("gate_valid", anyv, 0);
    chk("gate_ovf", ovf0, 0);
    chk_bytes("nogate", got1, expq);
    sync = 1'b1;

    // Reset mid-frame with two frames queued.
    apply_reset();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) offer(rnd_frame());
    chk("mid_level", level0, 2);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    apply_reset();
    anyv = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus0.data_valid || bus1.data_valid) anyv = 1;
      tick();
    end
    chk("post_rst_valid", anyv, 0);
    chk("post_rst_level", level0, 0);

    // Overflow counter saturation, preloaded close to the top.
    apply_reset();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) offer(rnd_frame());
    force u0.ovf_count = 16'hFFFA;
    #1;
    release u0.ovf_count;
    m_ovf = 16'hFFFA;
    for (int k = 0; k < 8; k++) offer(rnd_frame());
    chk("ovf_saturated", ovf0, 16'hFFFF);

    // Random traffic against the model.
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if (avail && bus0.pkt_ack) avail = 1'b0;
      else if (!avail && $urandom_range(0, 2) == 0) begin
        pin = rnd_frame();
        avail = 1'b1;
      end
      ready = ((c / 150) % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (c % 100 == 0) sync = ($urandom_range(0, 3) != 0);
      tick();
    end
    avail = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 100; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pack_fifo_sender.md
# pack_fifo_sender

Parametrised successor to the frame splitter between the trace interface and the UART. Accepts whole TPIU frames (FRAME_BYTES bytes wide) from the trace front end over an avail/ack handshake and buffers up to DEPTH frames. Serialises the frames LSB-byte-first onto a valid/ready byte stream for the UART or another transport. Adds frame-deep buffering, sync gating, a saturating overflow counter, a fill-level output and a stretched overflow indicator.

## Interface
- FRAME_BYTES, 16: bytes per frame; frame width is 8*FRAME_BYTES.
- DEPTH, 4: frame FIFO depth; power of two, 2 or more.
- SYNC_GATE, 1: 1 = frames offered while `sync`=0 are acked and discarded; 0 = all frames are buffered.
- OVF_STRETCH, 4_800_000: cycles `ovf_led` is held after the last overflow (100 ms at 48 MHz).

Ports:
- clk  in  1  system clock (48 MHz PLL output).
- rst  in  1  reset; one clock, asynchronous, active-high.
- sync  in  1  trace-interface sync indicator.
- pkt_avail  in  1  frame available (level).
- pkt_in  in  8*FRAME_BYTES  frame data; stable while `pkt_avail`=1.
- pkt_ack  out  1  one-cycle capture acknowledge.
- data_out  out  8  current byte.
- data_valid  out  1  `data_out` is valid.
- data_ready  in  1  consumer accepts the byte (UART tx_free).
- level  out  $clog2(DEPTH)+1  frames held in the FIFO (excludes the output stage).
- ovf_count  out  16  frames lost to a full FIFO; saturates at 16'hFFFF.
- ovf_led  out  1  stretched overflow indicator.

## Operation
- Reset values: pkt_ack=0, data_out=0, data_valid=0, level=0, ovf_count=0, ovf_led=0.
- Capture condition: `pkt_avail`=1 and registered `pkt_ack`=0. On a capture edge, `pkt_ack` goes to 1 for exactly one cycle.
- Producer rule: the producer drops `pkt_avail` within 1 cycle of seeing `pkt_ack`. The ack-low qualifier prevents a double capture.
- Disposition of a captured frame, in priority order:
  - SYNC_GATE=1 and `sync`=0: discard. No counter changes.
  - FIFO full and no pop on the same edge: discard. `ovf_count` increments (saturating) and the stretch counter reloads to OVF_STRETCH.
  - Otherwise: write to the FIFO tail.
- A frame is always acked, whatever its disposition.
- Output stage: a frame-wide shift register plus a byte index (0..FRAME_BYTES-1).
  - `data_out` = byte[index], where byte 0 = pkt_in[7:0].
  - Stage states:
    - EMPTY: data_valid=0.
    - SENDING: data_valid=1.
  - EMPTY -> SENDING: when the FIFO is non-empty. Pop the head, load it, index=0.
  - SENDING, on `data_valid`&`data_ready`:
    - index < FRAME_BYTES-1: advance the index.
    - Last byte, FIFO non-empty: pop and reload on the same edge. No bubble.
    - Last byte, FIFO empty: go to EMPTY.
- `data_out` does not change while data_valid=1 and data_ready=0.
- Same-edge push and pop: `level` is unchanged.
- Same-edge push and pop on a full FIFO: the push is accepted.
- `ovf_led` = (stretch counter != 0). The stretch counter decrements once per cycle to 0.
- Reset mid-frame: all state clears asynchronously. Any partially sent frame is lost, and no byte is emitted after reset until a new frame is captured.

## Timing
- Capture into empty FIFO and empty stage:
  - Edge E0: write to the FIFO; level=1.
  - Edge E1: pop and load; level=0, data_valid=1 in the cycle after E1.
  - First byte is available 2 edges after capture.
- Throughput: one byte per cycle while data_ready=1, including across frame boundaries.
- `pkt_ack` is asserted in the cycle after the capture edge. Maximum capture rate is one frame per 2 cycles.
- `level` and `ovf_count` are registered and update on the edge of the event.

## Structure
- Shared package `orbtrace_pkg`:
  - localparams FRAME_BYTES_DEFAULT=16 and SYSCLK_HZ=48_000_000.
  - Constant TPIU_FRAME_W=128.
- Sub-module `frame_fifo`: DEPTH×WIDTH synchronous FIFO.
  - Pointer width is $clog2(DEPTH)+1, with wrap-around via the extra MSB.
  - Exposes full, empty, count, push, pop, and a registered head-data output.
- The top of the block holds the handshake, sync gate, output stage, counters and stretcher.

## Test plan
- Single frame 128'h0F0E…0100, data_ready=1, sync=1 -> bytes 00,01,…,0F on consecutive cycles; first data_valid 2 edges after capture; pkt_ack high 1 cycle.
- Back-to-back: 6 frames offered with data_ready=0, DEPTH=4 -> level saturates at 4; output stage holds 1 frame; ovf_count=1; ovf_led=1 for OVF_STRETCH cycles (use OVF_STRETCH=16 in the bench).
- Stall: toggle data_ready on alternate cycles mid-frame -> data_out holds steady while stalled; no byte lost or duplicated; two frames streamed with no gap when data_ready=1 continuously.
- SYNC_GATE=1, sync=0, frame offered -> pkt_ack pulses; level stays 0; ovf_count unchanged; no data_valid. With SYNC_GATE=0 the same frame is output.
- Reset asserted after byte 5 of a frame, with 2 frames queued -> all outputs go to reset values immediately (asynchronously); after release no output until a new capture.
- ovf_count preloaded near saturation by 65 540 overflows (short test) -> holds at 16'hFFFF.
